// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, op codes and FSM state encoding for the ALU arbiter
package alu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int OP_W_DEF   = 3;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU shared by both requesters
module alu_arbiter_alu
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [OP_W-1:0]   op,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              illegal
);

   // Unknown codes leave result at zero, which also makes zero assert.
   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (op)
         OP_W'(OP_ADD): result = a + b;
         OP_W'(OP_SUB): result = a - b;
         OP_W'(OP_AND): result = a & b;
         OP_W'(OP_OR):  result = a | b;
         default:       illegal = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end to one ALU; ALU_ARB_PERF_EN adds grant counters
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_illegal
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1
`endif
);

   logic [1:0]        state;
   logic              last_grant;
   logic [DATA_W-1:0] lat_a;
   logic [DATA_W-1:0] lat_b;
   logic [OP_W-1:0]   lat_op;
   logic              lat_id;
   logic              idle;
   logic              grant0;
   logic              grant1;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_illegal;

   // Requester 0 wins unless requester 1 is also asking and 0 was served last.
   assign idle       = (state == ST_IDLE);
   assign grant0     = idle & req0_valid & (~req1_valid | last_grant);
   assign grant1     = idle & req1_valid & ~grant0;
   assign req0_ready = grant0;
   assign req1_ready = grant1;

   alu_arbiter_alu #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_alu (
      .a       (lat_a),
      .b       (lat_b),
      .op      (lat_op),
      .result  (alu_result),
      .zero    (alu_zero),
      .illegal (alu_illegal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         last_grant  <= 1'b1;
         lat_a       <= '0;
         lat_b       <= '0;
         lat_op      <= '0;
         lat_id      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_id      <= 1'b0;
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_illegal <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant0 | grant1) begin
                  lat_a      <= grant1 ? req1_a  : req0_a;
                  lat_b      <= grant1 ? req1_b  : req0_b;
                  lat_op     <= grant1 ? req1_op : req0_op;
                  lat_id     <= grant1;
                  last_grant <= grant1;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result  <= alu_result;
               rsp_zero    <= alu_zero;
               rsp_illegal <= alu_illegal;
               rsp_id      <= lat_id;
               rsp_valid   <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized scoreboard bench for alu_arbiter
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_op, req1_op;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
   logic [31:0] rsp_result;
`ifdef ALU_ARB_PERF_EN
   logic [15:0] gc0, gc1;
`endif

   alu_arbiter #(.DATA_W(32), .OP_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_op     (req0_op),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_op     (req1_op),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .rsp_zero    (rsp_zero),
      .rsp_illegal (rsp_illegal)
`ifdef ALU_ARB_PERF_EN
      ,
      .grant_cnt0  (gc0),
      .grant_cnt1  (gc1)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        id;
      logic [31:0] result;
      logic        zero;
      logic        illegal;
      int          gcyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   bit          outstanding = 1'b0;
   int          rr_mode = 1;
   int          last_g = 1;
   bit          act[2];
   logic [31:0] ra[2], rb[2];
   logic [2:0]  rop[2];

   bit          mon_hold = 1'b0;
   logic        s_id, s_zero, s_ill;
   logic [31:0] s_res;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Reference: plain modular arithmetic on wide integers.
   function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, input int g);
      exp_t e;
      longint unsigned m  = 64'd1 << 32;
      longint unsigned av = a;
      longint unsigned bv = b;
      e.id      = id;
      e.gcyc    = g;
      e.illegal = 1'b0;
      case (op)
         3'd0:    e.result = 32'((av + bv) % m);
         3'd1:    e.result = 32'((av + m - bv) % m);
         3'd2:    e.result = a & b;
         3'd3:    e.result = a | b;
         default: begin e.result = 32'd0; e.illegal = 1'b1; end
      endcase
      e.zero = (e.result == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [2:0] rnd_op();
      if ($urandom_range(0, 9) < 8) return 3'($urandom_range(0, 3));
      return 3'($urandom_range(4, 7));
   endfunction

   // mode 0: random traffic, 1: both requesters always SUB 3-3, 2: directed (no new requests)
   task automatic step(input int mode);
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (mode == 1) begin
            act[i] = 1'b1; ra[i] = 32'd3; rb[i] = 32'd3; rop[i] = 3'd1;
         end else if (mode == 0) begin
            if (!act[i] && $urandom_range(0, 2) == 0) begin
               act[i] = 1'b1; ra[i] = rnd_operand(); rb[i] = rnd_operand(); rop[i] = rnd_op();
            end else if (act[i] && outstanding && $urandom_range(0, 7) == 0) begin
               act[i] = 1'b0;
            end
         end
      end
      req0_valid = act[0]; req0_a = ra[0]; req0_b = rb[0]; req0_op = rop[0];
      req1_valid = act[1]; req1_a = ra[1]; req1_b = rb[1]; req1_op = rop[1];
      #2;
      if (!outstanding && (act[0] || act[1])) begin
         int w;
         w = (act[0] && act[1]) ? ((last_g == 0) ? 1 : 0) : (act[0] ? 0 : 1);
         chk("req0_ready_grant", req0_ready, w == 0);
         chk("req1_ready_grant", req1_ready, w == 1);
         sb.push_back(model(w[0], ra[w], rb[w], rop[w], cyc));
         last_g      = w;
         outstanding = 1'b1;
         act[w]      = 1'b0;
      end else begin
         chk("req0_ready_quiet", req0_ready, 1'b0);
         chk("req1_ready_quiet", req1_ready, 1'b0);
      end
   endtask

   task automatic clear_inputs();
      act[0] = 1'b0; act[1] = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"},   rsp_valid,   1'b0);
      chk({tag, "_rsp_id"},      rsp_id,      1'b0);
      chk({tag, "_rsp_result"},  rsp_result,  32'd0);
      chk({tag, "_rsp_zero"},    rsp_zero,    1'b0);
      chk({tag, "_rsp_illegal"}, rsp_illegal, 1'b0);
   endtask

   // Assert reset between clock edges and check outputs before any edge arrives.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #2;
      reset = 1'b1;
      clear_inputs();
      #1;
      check_reset_outputs(tag);
      sb.delete();
      outstanding = 1'b0;
      last_g      = 1;
      @(negedge clk);
      #3;
      reset = 1'b0;
   endtask

   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         case (rr_mode)
            0:       rsp_ready = ($urandom_range(0, 2) != 0);
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // Monitor: compare against the scoreboard head and check stability while stalled.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            mon_hold = 1'b0;
         end else if (!rsp_valid) begin
            if (mon_hold) chk("rsp_valid_dropped", rsp_valid, 1'b1);
            mon_hold = 1'b0;
         end else if (sb.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 1'b0);
         end else begin
            if (!mon_hold) begin
               chk("rsp_id",      rsp_id,      sb[0].id);
               chk("rsp_result",  rsp_result,  sb[0].result);
               chk("rsp_zero",    rsp_zero,    sb[0].zero);
               chk("rsp_illegal", rsp_illegal, sb[0].illegal);
               chk("latency",     64'(cyc - sb[0].gcyc), 64'd2);
               s_id = rsp_id; s_res = rsp_result; s_zero = rsp_zero; s_ill = rsp_illegal;
            end else begin
               chk("stable_id",      rsp_id,      s_id);
               chk("stable_result",  rsp_result,  s_res);
               chk("stable_zero",    rsp_zero,    s_zero);
               chk("stable_illegal", rsp_illegal, s_ill);
            end
            if (rsp_ready) begin
               void'(sb.pop_front());
               mon_hold = 1'b0;
               @(posedge clk);
               #1;
               outstanding = 1'b0;
            end else begin
               mon_hold = 1'b1;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      ra[0] = '0; rb[0] = '0; rop[0] = '0; ra[1] = '0; rb[1] = '0; rop[1] = '0;
      req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
      #1;
      check_reset_outputs("por");
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b0;

      // single add from requester 0
      act[0] = 1'b1; ra[0] = 32'd5; rb[0] = 32'd7; rop[0] = 3'd0;
      repeat (6) step(2);

      // contention: grants must alternate
      repeat (18) step(1);
      repeat (8) step(2);

      // consumer stalls while response is held
      act[1] = 1'b1; ra[1] = 32'h0000_1234; rb[1] = 32'h0000_00F0; rop[1] = 3'd3;
      rr_mode = 2;
      repeat (9) step(2);
      rr_mode = 1;
      repeat (4) step(2);

      // illegal op code
      act[1] = 1'b1; ra[1] = 32'hDEAD_BEEF; rb[1] = 32'h1; rop[1] = 3'd7;
      repeat (5) step(2);

      // wrap-around add
      act[0] = 1'b1; ra[0] = 32'hFFFF_FFFF; rb[0] = 32'd1; rop[0] = 3'd0;
      repeat (5) step(2);

      // reset during EXEC, then no stale response and a fresh tie goes to requester 0
      act[0] = 1'b1; ra[0] = 32'd9; rb[0] = 32'd4; rop[0] = 3'd1;
      step(2);
      async_reset("rst_exec");
      repeat (6) step(2);
      act[0] = 1'b1; ra[0] = 32'd20; rb[0] = 32'd22; rop[0] = 3'd0;
      act[1] = 1'b1; ra[1] = 32'hF0;  rb[1] = 32'h0F;  rop[1] = 3'd2;
      repeat (10) step(2);

      // reset while a response is being held
      act[1] = 1'b1; ra[1] = 32'd5; rb[1] = 32'd7; rop[1] = 3'd0;
      rr_mode = 2;
      repeat (4) step(2);
      async_reset("rst_resp");
      rr_mode = 1;
      repeat (6) step(2);

      // randomized traffic with random back-pressure
      rr_mode = 0;
      repeat (600) step(0);

      rr_mode = 1;
      clear_inputs();
      repeat (10) step(2);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
